// File: rtl/cnn_pkg.sv
// Shared widths, feeder state encoding and phase codes for the conv window feeder.
package cnn_pkg;

  localparam int PIX_W = 8;
  localparam int FP_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    EMIT_TOP,
    EMIT_BOT,
    DONE
  } feeder_state_t;

  localparam logic PHASE_TOP = 1'b0;
  localparam logic PHASE_BOT = 1'b1;

  localparam logic [15:0] FP16_ONE = 16'h3C00;

endpackage

// File: rtl/conv_line_buffer.sv
// One-line pixel store: single shared address, combinational read returns the
// old word while the same word is being written this cycle.
module conv_line_buffer #(
  parameter int IMG_W  = 256,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wdata,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [IMG_W];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to 2x2 window operand bus: top row (W1/W2) then bottom
// row (W3/W4), each phase held HOLD cycles, for the half-rate conv datapath.
module conv_window_feeder #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int HOLD  = 2,
  parameter int PIX_W = cnn_pkg::PIX_W,
  parameter int FP_W  = cnn_pkg::FP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [FP_W-1:0]  w1,
  input  logic [FP_W-1:0]  w2,
  input  logic [FP_W-1:0]  w3,
  input  logic [FP_W-1:0]  w4,
  input  logic [FP_W-1:0]  bias,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] in_1,
  output logic [PIX_W-1:0] in_2,
  output logic [FP_W-1:0]  f1,
  output logic [FP_W-1:0]  f2,
  output logic [FP_W-1:0]  p,
  output logic             win_valid,
  output logic             win_phase,
  output logic             frame_done
);

  import cnn_pkg::*;

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  feeder_state_t state;

  logic [CW-1:0]    col_cnt;
  logic [RW-1:0]    row_cnt;
  logic [HW-1:0]    hold_cnt;
  logic [FP_W-1:0]  w1_r, w2_r, w3_r, w4_r, bias_r;
  logic [PIX_W-1:0] top_pix, prev_top, prev_cur;
  logic [PIX_W-1:0] bl_r, br_r;
  logic             last_win;
  logic             accept;
  logic             forms_window;

  assign accept       = (state == ACCEPT) && pix_valid;
  assign forms_window = (row_cnt != '0) && (col_cnt != '0);

  conv_line_buffer #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W),
    .ADDR_W(CW)
  ) u_line_buffer (
    .clk  (clk),
    .we   (accept),
    .addr (col_cnt),
    .wdata(pix_in),
    .rdata(top_pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col_cnt    <= '0;
      row_cnt    <= '0;
      hold_cnt   <= '0;
      w1_r       <= '0;
      w2_r       <= '0;
      w3_r       <= '0;
      w4_r       <= '0;
      bias_r     <= '0;
      prev_top   <= '0;
      prev_cur   <= '0;
      bl_r       <= '0;
      br_r       <= '0;
      last_win   <= 1'b0;
      pix_ready  <= 1'b0;
      in_1       <= '0;
      in_2       <= '0;
      f1         <= '0;
      f2         <= '0;
      p          <= '0;
      win_valid  <= 1'b0;
      win_phase  <= PHASE_TOP;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w1_r      <= w1;
            w2_r      <= w2;
            w3_r      <= w3;
            w4_r      <= w4;
            bias_r    <= bias;
            col_cnt   <= '0;
            row_cnt   <= '0;
            pix_ready <= 1'b1;
            state     <= ACCEPT;
          end
        end

        ACCEPT: begin
          if (pix_valid) begin
            prev_top <= top_pix;
            prev_cur <= pix_in;
            if (col_cnt == COL_LAST) begin
              col_cnt <= '0;
              row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
            // Top row goes straight onto the bus; only the bottom row is parked.
            if (forms_window) begin
              bl_r      <= prev_cur;
              br_r      <= pix_in;
              last_win  <= (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
              in_1      <= prev_top;
              in_2      <= top_pix;
              f1        <= w1_r;
              f2        <= w2_r;
              p         <= bias_r;
              win_valid <= 1'b1;
              win_phase <= PHASE_TOP;
              pix_ready <= 1'b0;
              hold_cnt  <= '0;
              state     <= EMIT_TOP;
            end
          end
        end

        EMIT_TOP: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt  <= '0;
            in_1      <= bl_r;
            in_2      <= br_r;
            f1        <= w3_r;
            f2        <= w4_r;
            win_phase <= PHASE_BOT;
            state     <= EMIT_BOT;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        EMIT_BOT: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt  <= '0;
            win_valid <= 1'b0;
            if (last_win) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              pix_ready <= 1'b1;
              state     <= ACCEPT;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        DONE: begin
          frame_done <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Randomized bench for conv_window_feeder against a frame/window-level model.
module tb_conv_window_feeder;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int HOLD  = 2;
  localparam int NWIN  = (IMG_H - 1) * (IMG_W - 1);
  localparam int NPIX  = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] w1 = '0, w2 = '0, w3 = '0, w4 = '0, bias = '0;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  in_1, in_2;
  logic [15:0] f1, f2, p;
  logic        win_valid, win_phase, frame_done;

  always #5 clk = ~clk;

  conv_window_feeder #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .HOLD (HOLD),
    .PIX_W(8),
    .FP_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .w4        (w4),
    .bias      (bias),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .in_1      (in_1),
    .in_2      (in_2),
    .f1        (f1),
    .f2        (f2),
    .p         (p),
    .win_valid (win_valid),
    .win_phase (win_phase),
    .frame_done(frame_done)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame image the producer is sending; the model reads windows out of it.
  logic [7:0] img [IMG_H][IMG_W];

  // Model: frame activity, remaining bus cycles of the current window.
  bit          mon_en = 1'b0;
  bit          m_active, m_done, m_last;
  int          m_busy, m_acc, m_wins;
  logic [15:0] m_w1, m_w2, m_w3, m_w4, m_b;
  logic [7:0]  m_tl, m_tr, m_bl, m_br;
  logic [7:0]  h_in1, h_in2;
  logic [15:0] h_f1, h_f2, h_p;
  logic        h_phase;
  int          dut_done_cnt = 0;
  int          valid_cycles = 0;
  logic [15:0] obs_top [NWIN];
  logic [15:0] obs_bot [NWIN];
  logic [31:0] obs_f_top, obs_f_bot;
  bit          exp_ready, top_ph, was_done;
  int          r, c;

  function automatic void model_reset();
    m_active = 0; m_done = 0; m_last = 0; m_busy = 0; m_acc = 0; m_wins = 0;
    m_w1 = '0; m_w2 = '0; m_w3 = '0; m_w4 = '0; m_b = '0;
    h_in1 = '0; h_in2 = '0; h_f1 = '0; h_f2 = '0; h_p = '0; h_phase = 1'b0;
  endfunction

  initial model_reset();

  always @(negedge clk) begin
    if (mon_en) begin
      exp_ready = m_active && (m_busy == 0) && !m_done;
      chk("pix_ready", pix_ready, exp_ready);
      chk("win_valid", win_valid, m_busy != 0);
      chk("frame_done", frame_done, m_done);
      if (frame_done) dut_done_cnt++;
      if (win_valid) valid_cycles++;
      if (m_busy != 0) begin
        top_ph  = m_busy > HOLD;
        h_phase = !top_ph;
        h_in1   = top_ph ? m_tl : m_bl;
        h_in2   = top_ph ? m_tr : m_br;
        h_f1    = top_ph ? m_w1 : m_w3;
        h_f2    = top_ph ? m_w2 : m_w4;
        h_p     = m_b;
        chk("win_phase", win_phase, h_phase);
        if (m_wins >= 1 && m_wins <= NWIN) begin
          if (m_busy == 2 * HOLD) obs_top[m_wins-1] = {in_1, in_2};
          if (m_busy == HOLD)     obs_bot[m_wins-1] = {in_1, in_2};
        end
        if (m_wins == 1 && m_busy == 2 * HOLD) obs_f_top = {f1, f2};
        if (m_wins == 1 && m_busy == HOLD)     obs_f_bot = {f1, f2};
      end
      // Outside a window the bus must still show whatever it last carried.
      chk("in_1", in_1, h_in1);
      chk("in_2", in_2, h_in2);
      chk("f1", f1, h_f1);
      chk("f2", f2, h_f2);
      chk("p", p, h_p);

      if (rst) begin
        model_reset();
      end else begin
        was_done = m_done;
        m_done   = 0;
        if (!m_active && !was_done && start) begin
          m_active = 1; m_acc = 0; m_wins = 0;
          m_w1 = w1; m_w2 = w2; m_w3 = w3; m_w4 = w4; m_b = bias;
        end else if (exp_ready && pix_valid) begin
          r = m_acc / IMG_W;
          c = m_acc % IMG_W;
          m_acc++;
          if (r >= 1 && c >= 1) begin
            m_tl = img[r-1][c-1]; m_tr = img[r-1][c];
            m_bl = img[r][c-1];   m_br = img[r][c];
            m_busy = 2 * HOLD;
            m_last = (r == IMG_H - 1) && (c == IMG_W - 1);
            m_wins++;
          end
        end else if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0 && m_last) begin
            m_done = 1; m_active = 0;
          end
        end
      end
    end
  end

  task automatic fill_img(input bit rnd);
    for (int rr = 0; rr < IMG_H; rr++)
      for (int cc = 0; cc < IMG_W; cc++)
        img[rr][cc] = rnd ? 8'($urandom) : 8'(16 * rr + cc);
  endtask

  task automatic start_frame(input logic [15:0] a, b, cc, d, e);
    w1 = a; w2 = b; w3 = cc; w4 = d; bias = e;
    valid_cycles = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_frame(input int gap_pct, input int mid_start_idx, input int abort_idx,
                            output bit aborted);
    aborted = 0;
    for (int i = 0; i < NPIX; i++) begin
      int guard = 0;
      bit taken = 0;
      pix_in = img[i / IMG_W][i % IMG_W];
      if (i == mid_start_idx) begin
        start = 1'b1;
        w1 = 16'h1234;
      end
      while (!taken) begin
        pix_valid = ($urandom_range(99) >= gap_pct);
        @(negedge clk);
        taken = pix_valid && pix_ready;
        @(posedge clk); #1;
        start = 1'b0;
        guard++;
        if (guard > 200) begin
          chk("pix_accept_timeout", 0, 1);
          pix_valid = 1'b0;
          return;
        end
      end
      if (i == abort_idx) begin
        pix_valid = 1'b0;
        rst = 1'b1;
        aborted = 1;
        return;
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n0 = dut_done_cnt;
    for (int k = 0; k < 60 && dut_done_cnt == n0; k++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("frame_done_count", dut_done_cnt - n0, 1);
    chk("window_cycles", valid_cycles, NWIN * 2 * HOLD);
  endtask

  task automatic pin_ramp_windows(input string tag);
    chk({tag, "_win0_top"}, obs_top[0], 16'h0001);
    chk({tag, "_win0_bot"}, obs_bot[0], 16'h1011);
    chk({tag, "_win5_top"}, obs_top[NWIN-1], 16'h1213);
    chk({tag, "_win5_bot"}, obs_bot[NWIN-1], 16'h2223);
  endtask

  initial begin
    bit ab;
    logic [15:0] rw1;
    int n0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_1", in_1, 0);
    chk("rst_f1", f1, 0);
    chk("rst_p", p, 0);
    mon_en = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp image, unit weights, no gaps
    fill_img(0);
    start_frame(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    send_frame(0, -1, -1, ab);
    wait_done();
    pin_ramp_windows("t1");

    // Distinct weights per tap
    start_frame(16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h3C00);
    send_frame(0, -1, -1, ab);
    wait_done();
    chk("t2_f_top", obs_f_top, 32'h3C004000);
    chk("t2_f_bot", obs_f_bot, 32'h42004400);

    // 50% producer gaps
    start_frame(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    send_frame(50, -1, -1, ab);
    wait_done();
    pin_ramp_windows("t3");

    // Mid-frame start with a changed w1 is ignored
    fill_img(1);
    rw1 = 16'($urandom);
    start_frame(rw1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    send_frame(30, 6, -1, ab);
    wait_done();
    chk("t4_f1_latched", obs_f_top[31:16], rw1);

    // Reset during the top phase of the third window
    fill_img(0);
    start_frame(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    n0 = dut_done_cnt;
    send_frame(0, -1, 7, ab);
    chk("t5_aborted", ab, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_win_valid", win_valid, 0);
    chk("t5_pix_ready", pix_ready, 0);
    chk("t5_frame_done", frame_done, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_done", dut_done_cnt - n0, 0);
    start_frame(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    send_frame(0, -1, -1, ab);
    wait_done();
    pin_ramp_windows("t5");

    // Random images, weights and gaps
    for (int f = 0; f < 4; f++) begin
      fill_img(1);
      start_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      send_frame(int'($urandom_range(70)), -1, -1, ab);
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
